// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution line-buffer path.
package conv_pkg;

    localparam int PIXEL_W     = 8;
    localparam int IMAGE_MAX_W = 1024;
    // Push-to-colD latency of the line buffer (SRAM read plus colD flop).
    localparam int LB_LAT      = 2;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LINE0 = 2'd1,
        LINEN = 2'd2,
        FLUSH = 2'd3
    } lb_seq_state_t;

    // One slot of the alignment pipe: the current pixel plus its tags.
    typedef struct packed {
        logic   vld;
        pixel_t dat;
        logic   top;
        logic   eol;
    } lb_entry_t;

endpackage

// File: rtl/conv_lb_seq_if.sv
// Signal bundle between the pixel source, the sequencer, the line buffer
// and the aligned-pixel consumer.
//
// Handshake: a pixel on s_* is transferred on a rising clk edge where
// s_vld_i and s_rdy_o are both 1. While s_vld_i is 1 and the pixel has not
// been transferred, the source holds s_dat_i/s_sof_i/s_eol_i/s_eof_i
// stable. s_rdy_o may fall and rise without a transfer. o_rdy_i is the
// downstream stall: with o_rdy_i = 0 nothing is pushed and nothing is
// accepted. state_o exposes the sequencer FSM for observation.
interface conv_lb_seq_if;
    import conv_pkg::*;

    logic          s_vld_i;
    logic          s_rdy_o;
    pixel_t        s_dat_i;
    logic          s_sof_i;
    logic          s_eol_i;
    logic          s_eof_i;
    logic          o_rdy_i;
    logic          lb_push_o;
    logic          lb_pop_o;
    pixel_t        lb_dat_o;
    logic          lb_sof_o;
    logic          lb_eol_o;
    logic          o_vld_o;
    pixel_t        o_dat_o;
    logic          o_top_o;
    logic          o_eol_o;
    logic          err_o;
    lb_seq_state_t state_o;

    // Sequencer side.
    modport slave (
        input  s_vld_i, s_dat_i, s_sof_i, s_eol_i, s_eof_i, o_rdy_i,
        output s_rdy_o, lb_push_o, lb_pop_o, lb_dat_o, lb_sof_o, lb_eol_o,
        output o_vld_o, o_dat_o, o_top_o, o_eol_o, err_o, state_o
    );

    // Source / consumer side.
    modport master (
        output s_vld_i, s_dat_i, s_sof_i, s_eol_i, s_eof_i, o_rdy_i,
        input  s_rdy_o, lb_push_o, lb_pop_o, lb_dat_o, lb_sof_o, lb_eol_o,
        input  o_vld_o, o_dat_o, o_top_o, o_eol_o, err_o, state_o
    );

endinterface

// File: rtl/conv_lb_align_pipe.sv
// Enable-gated shift register that delays the current pixel by the line
// buffer read latency so it leaves alongside colD.
module conv_lb_align_pipe
    import conv_pkg::*;
#(
    parameter int DEPTH = conv_pkg::LB_LAT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  lb_entry_t din,
    output lb_entry_t tail
);

    lb_entry_t pipe [DEPTH];

    // Shift only on line-buffer pushes; only the valid bits need a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i].vld <= 1'b0;
            end
        end else if (en) begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail = pipe[DEPTH-1];

endmodule

// File: rtl/conv_lb_seq.sv
// Sequencer in front of the line-buffer controller: turns the pixel stream
// into push/pop/sof/eol beats, tracks line width, and re-aligns the current
// pixel with the buffer's colD output.
module conv_lb_seq #(
    parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W,
    parameter int LB_LAT      = conv_pkg::LB_LAT
) (
    input logic          clk,
    input logic          rst,
    conv_lb_seq_if.slave bus
);
    import conv_pkg::*;

    localparam int COL_W = $clog2(IMAGE_MAX_W + 1);
    localparam int FL_W  = (LB_LAT > 1) ? $clog2(LB_LAT) : 1;
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(LB_LAT - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMAGE_MAX_W - 1);

    lb_seq_state_t    state, state_nxt;
    logic [COL_W-1:0] col, width_r, cur_col, col_inc;
    logic [FL_W-1:0]  flush_cnt;
    logic             s_rdy, acc, act, flush_beat, push;
    logic             in_line0, ovf, pix_eol, frame_end, width_bad;
    lb_entry_t        pipe_in, pipe_tail;

    // Beat qualification. IDLE swallows pixels that do not open a frame;
    // act marks pixels that really enter the line buffer.
    always_comb begin
        s_rdy      = (state != FLUSH) && bus.o_rdy_i;
        acc        = bus.s_vld_i && s_rdy;
        act        = acc && ((state != IDLE) || bus.s_sof_i);
        flush_beat = (state == FLUSH) && bus.o_rdy_i;
        push       = act || flush_beat;
        // A sof pixel always starts a first line, whatever the state.
        in_line0   = bus.s_sof_i || (state == LINE0);
        cur_col    = bus.s_sof_i ? '0 : col;
        col_inc    = cur_col + COL_W'(1);
        ovf        = (cur_col == COL_LAST) && !bus.s_eol_i;
        pix_eol    = bus.s_eol_i || ovf;
        frame_end  = bus.s_eol_i && bus.s_eof_i;
        width_bad  = !in_line0 && pix_eol && (col_inc != width_r);
    end

    // Next-state logic for the line sequencer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, LINE0, LINEN: begin
                if (act) begin
                    if (frame_end)     state_nxt = FLUSH;
                    else if (pix_eol)  state_nxt = LINEN;
                    else if (in_line0) state_nxt = LINE0;
                    else               state_nxt = LINEN;
                end
            end
            FLUSH: begin
                if (flush_beat && (flush_cnt == FLUSH_LAST)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Column/width tracking and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            width_r <= '0;
            bus.err_o <= 1'b0;
        end else if (act) begin
            col <= pix_eol ? '0 : col_inc;
            if (in_line0 && pix_eol) width_r <= col_inc;
            if (ovf || width_bad) bus.err_o <= 1'b1;
        end
    end

    // Counts the empty beats that drain the buffer at end of frame.
    always_ff @(posedge clk) begin
        if (rst)             flush_cnt <= '0;
        else if (flush_beat) flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + FL_W'(1);
    end

    // Entry loaded into the alignment pipe on every push; flush beats carry no pixel.
    always_comb begin
        pipe_in.vld = act;
        pipe_in.dat = bus.s_dat_i;
        pipe_in.top = in_line0;
        pipe_in.eol = pix_eol;
    end

    conv_lb_align_pipe #(.DEPTH(LB_LAT)) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .en   (push),
        .din  (pipe_in),
        .tail (pipe_tail)
    );

    // Aligned valid: one cycle after the push that shifted a pixel out.
    always_ff @(posedge clk) begin
        if (rst) bus.o_vld_o <= 1'b0;
        else     bus.o_vld_o <= push && pipe_tail.vld;
    end

    // Aligned payload, captured on the same enable, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            bus.o_dat_o <= pipe_tail.dat;
            bus.o_top_o <= pipe_tail.top;
            bus.o_eol_o <= pipe_tail.eol;
        end
    end

    assign bus.s_rdy_o   = s_rdy;
    assign bus.lb_push_o = push;
    assign bus.lb_pop_o  = flush_beat || (act && (state == LINEN) && !bus.s_sof_i);
    assign bus.lb_dat_o  = act ? bus.s_dat_i : '0;
    assign bus.lb_sof_o  = act && bus.s_sof_i;
    assign bus.lb_eol_o  = act && pix_eol;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_conv_lb_seq.sv
// Bench for conv_lb_seq: directed frames plus randomized frames, checked
// against a frame-level model of lines, widths and output latency.
module tb_conv_lb_seq;
    import conv_pkg::*;

    localparam int EXP_W = 32 + PIXEL_W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_lb_seq_if bus ();

    conv_lb_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EXP_W-1:0] exp_q [$];   // {push index, dat, top, eol}

    bit mon_on     = 1'b0;
    bit in_frame   = 1'b0;
    int line_idx   = 0;
    int col_m      = 0;
    int width_m    = 0;
    bit err_exp    = 1'b0;
    int flush_left = 0;
    int flush_seen = 0;
    int push_cnt   = 0;
    bit prev_push  = 1'b0;
    int last_idx   = 0;
    int out_cnt    = 0;

    int ordy_mode  = 0;
    int gap_max    = 0;
    int pix_n      = 1;
    bit seq_data   = 1'b1;
    int widths [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Downstream ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ordy_mode)
            0:       bus.o_rdy_i = 1'b1;
            1:       bus.o_rdy_i = ~bus.o_rdy_i;
            default: bus.o_rdy_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Reference model and comparisons, evaluated mid-cycle.
    always @(negedge clk) begin
        logic             due;
        logic [EXP_W-1:0] e;
        bit               mism;
        if (mon_on) begin
            // Registered outputs reflect the previous edge.
            check("err", bus.err_o, err_exp);
            due = 1'b0;
            if (prev_push && exp_q.size() > 0) begin
                e = exp_q[0];
                due = (int'(e[EXP_W-1 -: 32]) + LB_LAT == last_idx);
            end
            check("o_vld", bus.o_vld_o, due);
            if (due) begin
                e = exp_q.pop_front();
                out_cnt++;
                check("o_dat", bus.o_dat_o, e[PIXEL_W+1:2]);
                check("o_top", bus.o_top_o, e[1]);
                check("o_eol", bus.o_eol_o, e[0]);
            end

            if (rst) begin
                exp_q.delete();
                in_frame   = 1'b0;
                line_idx   = 0;
                col_m      = 0;
                err_exp    = 1'b0;
                flush_left = 0;
                prev_push  = 1'b0;
            end else begin
                mism = 1'b0;
                if (!bus.o_rdy_i) check("push_gated", bus.lb_push_o, 0);
                if (flush_left > 0) check("rdy_in_flush", bus.s_rdy_o, 0);
                if (bus.s_vld_i && bus.s_rdy_o) begin
                    if (!in_frame && !bus.s_sof_i) begin
                        check("drop_no_push", bus.lb_push_o, 0);
                    end else begin
                        if (bus.s_sof_i) begin
                            in_frame = 1'b1;
                            line_idx = 0;
                            col_m    = 0;
                        end
                        check("push", bus.lb_push_o, 1);
                        check("pop", bus.lb_pop_o, (line_idx > 0));
                        check("lb_dat", bus.lb_dat_o, bus.s_dat_i);
                        check("lb_sof", bus.lb_sof_o, bus.s_sof_i);
                        check("lb_eol", bus.lb_eol_o, bus.s_eol_i);
                        exp_q.push_back({push_cnt[31:0], bus.s_dat_i, (line_idx == 0), bus.s_eol_i});
                        col_m++;
                        if (bus.s_eol_i) begin
                            if (line_idx == 0) width_m = col_m;
                            else if (col_m != width_m) mism = 1'b1;
                            line_idx++;
                            col_m = 0;
                            if (bus.s_eof_i) begin
                                in_frame   = 1'b0;
                                flush_left = LB_LAT;
                            end
                        end
                    end
                end else if (bus.lb_push_o) begin
                    check("flush_expected", (flush_left > 0), 1);
                    check("flush_pop", bus.lb_pop_o, 1);
                    check("flush_dat", bus.lb_dat_o, 0);
                    flush_left--;
                    flush_seen++;
                end else if (flush_left > 0 && bus.o_rdy_i) begin
                    check("flush_missing", bus.lb_push_o, 1);
                end
                prev_push = bus.lb_push_o;
                if (bus.lb_push_o) begin
                    last_idx = push_cnt;
                    push_cnt++;
                end
                if (mism) err_exp = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_px(input bit sof, input bit eol, input bit eof);
        int t = 0;
        bus.s_vld_i = 1'b1;
        bus.s_dat_i = seq_data ? pixel_t'(pix_n) : pixel_t'($urandom_range(0, 255));
        bus.s_sof_i = sof;
        bus.s_eol_i = eol;
        bus.s_eof_i = eof;
        pix_n++;
        @(negedge clk);
        while (!bus.s_rdy_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept", bus.s_rdy_o, 1);
        @(posedge clk);
        #1;
        bus.s_vld_i = 1'b0;
        bus.s_sof_i = 1'b0;
        bus.s_eol_i = 1'b0;
        bus.s_eof_i = 1'b0;
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_line(input int w, input bit first, input bit last);
        for (int c = 0; c < w; c++) begin
            send_px(first && c == 0, c == w - 1, last && c == w - 1);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.state_o != IDLE && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reach_idle", bus.state_o, IDLE);
        repeat (LB_LAT + 2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int n_lines);
        flush_seen = 0;
        for (int l = 0; l < n_lines; l++) begin
            send_line(widths[l], l == 0, l == n_lines - 1);
        end
        wait_idle();
        check("flush_beats", flush_seen, LB_LAT);
    endtask

    task automatic do_reset();
        bus.s_vld_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_state", bus.state_o, IDLE);
        check("rst_o_vld", bus.o_vld_o, 0);
        check("rst_err", bus.err_o, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_l, w;
        bus.s_vld_i = 1'b0;
        bus.s_dat_i = '0;
        bus.s_sof_i = 1'b0;
        bus.s_eol_i = 1'b0;
        bus.s_eof_i = 1'b0;
        bus.o_rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;
        check("init_state", bus.state_o, IDLE);
        check("init_o_vld", bus.o_vld_o, 0);
        check("init_err", bus.err_o, 0);

        // 4x3 frame, pixels 1..12, always ready.
        widths = '{4, 4, 4, 0, 0, 0, 0, 0};
        out_cnt = 0;
        pix_n = 1;
        send_frame(3);
        check("f1_outputs", out_cnt, 12);
        check("f1_err", bus.err_o, 0);

        // Same frame with downstream ready toggling.
        ordy_mode = 1;
        out_cnt = 0;
        pix_n = 1;
        send_frame(3);
        check("f2_outputs", out_cnt, 12);
        ordy_mode = 0;

        // Widths 4,3,4: error on line 2, sticky through the next frame.
        widths = '{4, 3, 4, 0, 0, 0, 0, 0};
        send_frame(3);
        check("mismatch_err", bus.err_o, 1);
        widths = '{4, 4, 4, 0, 0, 0, 0, 0};
        send_frame(3);
        check("err_sticky", bus.err_o, 1);

        // Pixels without sof while idle are swallowed.
        do_reset();
        for (int i = 0; i < 3; i++) send_px(1'b0, (i == 2), 1'b0);
        check("drop_state", bus.state_o, IDLE);
        send_frame(2);

        // sof in the middle of line 2 restarts at the first line.
        send_line(4, 1'b1, 1'b0);
        send_px(1'b0, 1'b0, 1'b0);
        send_px(1'b0, 1'b0, 1'b0);
        send_px(1'b1, 1'b0, 1'b0);
        check("restart_state", bus.state_o, LINE0);
        send_px(1'b0, 1'b0, 1'b0);
        send_px(1'b0, 1'b0, 1'b0);
        send_px(1'b0, 1'b1, 1'b0);
        send_line(4, 1'b0, 1'b1);
        wait_idle();
        check("restart_err", bus.err_o, 0);

        // Reset in the middle of a non-first line, then a clean frame.
        send_line(4, 1'b1, 1'b0);
        send_px(1'b0, 1'b0, 1'b0);
        check("pre_rst_state", bus.state_o, LINEN);
        do_reset();
        out_cnt = 0;
        pix_n = 1;
        send_frame(3);
        check("post_rst_outputs", out_cnt, 12);
        check("post_rst_err", bus.err_o, 0);

        // Randomized frames, random stalls, gaps and occasional width errors.
        ordy_mode = 2;
        gap_max   = 2;
        seq_data  = 1'b0;
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 5) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) send_px(1'b0, 1'b1, 1'b0);
            n_l = $urandom_range(1, 4);
            w   = $urandom_range(1, 6);
            for (int l = 0; l < 8; l++) begin
                widths[l] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : w;
            end
            send_frame(n_l);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
